// File: rtl/packet_classifier_if.sv
// packet_classifier_if: ingress beat stream plus the classification result
// channel, bundled so the classifier and its environment share one bus.
interface packet_classifier_if #(
    parameter int DATA_WIDTH   = 256,
    parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
    parameter int PAYLOAD_BITS = 336
);
    // Ingress stream (byte 0 is the MSB byte of s_tdata)
    logic [DATA_WIDTH-1:0]   s_tdata;
    logic [KEEP_WIDTH-1:0]   s_tkeep;
    logic                    s_tvalid;
    logic                    s_tlast;
    logic                    s_tready;

    // Classification result
    logic                    m_valid;
    logic                    m_ready;
    logic [31:0]             dest_ip;
    logic [15:0]             dest_port;
    logic [PAYLOAD_BITS-1:0] payload;
    logic                    match;
    logic [3:0]              match_idx;
    logic                    err_short;
    logic                    err_long;

    // Environment side: drives beats upstream, consumes results downstream
    modport master (
        output s_tdata, s_tkeep, s_tvalid, s_tlast, m_ready,
        input  s_tready, m_valid, dest_ip, dest_port, payload,
               match, match_idx, err_short, err_long
    );

    // Classifier side
    modport slave (
        input  s_tdata, s_tkeep, s_tvalid, s_tlast, m_ready,
        output s_tready, m_valid, dest_ip, dest_port, payload,
               match, match_idx, err_short, err_long
    );
endinterface

// File: rtl/packet_classifier.sv
// packet_classifier: captures up to MAX_BEATS beats of a packet, extracts
// destination IP/port and payload at fixed byte offsets, matches an 8-byte
// signature against a programmable table and presents the result on a
// valid/ready channel together with error flags and statistics counters.
module packet_classifier #(
    parameter int DATA_WIDTH = 256,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int MAX_BEATS  = 3,
    parameter int IP_BYTE    = 14,
    parameter int PORT_BYTE  = 34,
    parameter int SIG_BYTE   = 54,
    parameter int NUM_SIGS   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    packet_classifier_if.slave     bus,
    input  logic [NUM_SIGS*64-1:0] sig_table_i,
    input  logic [NUM_SIGS-1:0]    sig_enable_i,
    output logic [31:0]            cnt_pkts_o,
    output logic [31:0]            cnt_match_o,
    output logic [31:0]            cnt_err_o
);
    localparam int CAP_BITS     = MAX_BEATS * DATA_WIDTH;
    localparam int CAP_BYTES    = CAP_BITS / 8;
    localparam int PAYLOAD_BITS = CAP_BITS - 8 * SIG_BYTE;
    localparam int BEAT_W       = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam int CNT_W        = $clog2(CAP_BYTES + 1);

    typedef enum logic [1:0] {COLLECT, DRAIN, EVAL, OUT} state_e;

    state_e                  state_q;
    logic [BEAT_W-1:0]       beat_q;
    logic [CNT_W-1:0]        byte_cnt_q, byte_cnt_d;
    logic                    long_q;
    logic [CAP_BITS-1:0]     cap_q, cap_d;

    logic                    m_valid_q;
    logic [31:0]             dest_ip_q;
    logic [15:0]             dest_port_q;
    logic [PAYLOAD_BITS-1:0] payload_q;
    logic                    match_q;
    logic [3:0]              match_idx_q;
    logic                    err_short_q;
    logic                    err_long_q;
    logic [31:0]             cnt_pkts_q, cnt_match_q, cnt_err_q;

    logic                    s_tready;
    logic                    beat_fire;
    logic [DATA_WIDTH-1:0]   beat_masked;
    logic [CNT_W-1:0]        keep_pop;
    logic [63:0]             sig_field;
    logic                    hit;
    logic [3:0]              hit_idx;
    logic                    short_pkt;
    logic                    match_d;
    logic [3:0]              match_idx_d;

    assign s_tready  = !rst && (state_q == COLLECT || state_q == DRAIN);
    assign beat_fire = bus.s_tvalid && s_tready;

    // Build the next capture buffer image and byte count for an accepted beat.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
        beat_masked = bus.s_tdata;
        keep_pop    = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            keep_pop = keep_pop + CNT_W'(bus.s_tkeep[i]);
            if (bus.s_tlast && !bus.s_tkeep[KEEP_WIDTH-1-i])
                beat_masked[DATA_WIDTH-1-8*i -: 8] = 8'h00;
        end
        byte_cnt_d = CNT_W'(beat_q) * CNT_W'(KEEP_WIDTH)
                   + (bus.s_tlast ? keep_pop : CNT_W'(KEEP_WIDTH));
        // The first beat of a packet clears every slot it does not write.
        cap_d = (beat_q == '0) ? '0 : cap_q;
        for (int k = 0; k < MAX_BEATS; k++) begin
            if (beat_q == BEAT_W'(k))
                cap_d[CAP_BITS-1-k*DATA_WIDTH -: DATA_WIDTH] = beat_masked;
        end
    end

    // Signature lookup over the captured buffer; lowest enabled hit wins.
    always_comb begin
        sig_field = cap_q[CAP_BITS-1-8*SIG_BYTE -: 64];
        hit       = 1'b0;
        hit_idx   = 4'd0;
        for (int i = NUM_SIGS - 1; i >= 0; i--) begin
            if (sig_enable_i[i] && sig_table_i[64*i +: 64] == sig_field) begin
                hit     = 1'b1;
                hit_idx = 4'(i);
            end
        end
        short_pkt   = int'(byte_cnt_q) < SIG_BYTE + 8;
        match_d     = hit && !short_pkt;
        match_idx_d = match_d ? hit_idx : 4'd0;
    end

    // Packet FSM with registered result outputs and statistics counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= COLLECT;
            beat_q      <= '0;
            byte_cnt_q  <= '0;
            long_q      <= 1'b0;
            // NOTE: the capture buffer is ordinary flops, not a RAM, so it is cleared on reset like any other state.
            cap_q       <= '0;
            m_valid_q   <= 1'b0;
            dest_ip_q   <= '0;
            dest_port_q <= '0;
            payload_q   <= '0;
            match_q     <= 1'b0;
            match_idx_q <= '0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
            cnt_pkts_q  <= '0;
            cnt_match_q <= '0;
            cnt_err_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            case (state_q)
                COLLECT: begin
                    if (beat_fire) begin
                        cap_q      <= cap_d;
                        byte_cnt_q <= byte_cnt_d;
                        if (bus.s_tlast) begin
                            beat_q  <= '0;
                            state_q <= EVAL;
                        end else if (beat_q == BEAT_W'(MAX_BEATS - 1)) begin
                            beat_q  <= '0;
                            long_q  <= 1'b1;
                            state_q <= DRAIN;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (beat_fire && bus.s_tlast)
                        state_q <= EVAL;
                end
                EVAL: begin
                    dest_ip_q   <= cap_q[CAP_BITS-1-8*IP_BYTE -: 32];
                    dest_port_q <= cap_q[CAP_BITS-1-8*PORT_BYTE -: 16];
                    payload_q   <= cap_q[PAYLOAD_BITS-1:0];
                    match_q     <= match_d;
                    match_idx_q <= match_idx_d;
                    err_short_q <= short_pkt;
                    err_long_q  <= long_q;
                    cnt_pkts_q  <= cnt_pkts_q + 32'd1;
                    cnt_match_q <= cnt_match_q + {31'd0, match_d};
                    cnt_err_q   <= cnt_err_q + {31'd0, short_pkt || long_q};
                    long_q      <= 1'b0;
                    m_valid_q   <= 1'b1;
                    state_q     <= OUT;
                end
                OUT: begin
                    if (bus.m_ready) begin
                        m_valid_q <= 1'b0;
                        state_q   <= COLLECT;
                    end
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

    assign bus.s_tready  = s_tready;
    assign bus.m_valid   = m_valid_q;
    assign bus.dest_ip   = dest_ip_q;
    assign bus.dest_port = dest_port_q;
    assign bus.payload   = payload_q;
    assign bus.match     = match_q;
    assign bus.match_idx = match_idx_q;
    assign bus.err_short = err_short_q;
    assign bus.err_long  = err_long_q;
    assign cnt_pkts_o    = cnt_pkts_q;
    assign cnt_match_o   = cnt_match_q;
    assign cnt_err_o     = cnt_err_q;
endmodule

// File: tb/tb_packet_classifier.sv
// tb_packet_classifier: directed packets with hand-computed results; expected
// results are queued at issue time and a monitor compares them whenever the
// classifier presents m_valid.
module tb_packet_classifier;
    localparam int DW        = 256;
    localparam int KW        = DW / 8;
    localparam int MB        = 3;
    localparam int NS        = 2;
    localparam int SIG_BYTE  = 54;
    localparam int CAP_BYTES = MB * KW;
    localparam int PB        = (CAP_BYTES - SIG_BYTE) * 8;
    localparam logic [63:0] PNG   = 64'h89504E470D0A1A0A;
    localparam logic [63:0] OTHER = 64'h0123456789ABCDEF;
    localparam logic [63:0] DEAD  = 64'hDEADBEEFCAFEF00D;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NS*64-1:0]  sig_table;
    logic [NS-1:0]     sig_enable;
    logic [31:0]       cnt_pkts, cnt_match, cnt_err;

    packet_classifier_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .PAYLOAD_BITS(PB)) bus ();

    packet_classifier #(
        .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .MAX_BEATS(MB), .IP_BYTE(14),
        .PORT_BYTE(34), .SIG_BYTE(SIG_BYTE), .NUM_SIGS(NS)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .sig_table_i(sig_table), .sig_enable_i(sig_enable),
        .cnt_pkts_o(cnt_pkts), .cnt_match_o(cnt_match), .cnt_err_o(cnt_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]   ip;
        logic [15:0]   port;
        logic [PB-1:0] payload;
        logic          m;
        logic [3:0]    idx;
        logic          es;
        logic          el;
        logic [31:0]   cp, cm, ce;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] pkt [0:159];

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic fill_packet(input int seed, input logic [31:0] ip, input logic [15:0] port,
                               input logic [63:0] sig);
        for (int b = 0; b < 160; b++) pkt[b] = 8'(((b * 5 + seed * 29) % 255) + 1);
        for (int i = 0; i < 4; i++) pkt[14+i] = ip[31-8*i -: 8];
        for (int i = 0; i < 2; i++) pkt[34+i] = port[15-8*i -: 8];
        for (int i = 0; i < 8; i++) pkt[SIG_BYTE+i] = sig[63-8*i -: 8];
    endtask

    task automatic push_exp(input logic [31:0] ip, input logic [15:0] port, input int len,
                            input logic m, input logic [3:0] idx, input logic es, input logic el,
                            input int cp, input int cm, input int ce);
        exp_t e;
        e.ip = ip; e.port = port; e.m = m; e.idx = idx; e.es = es; e.el = el;
        e.payload = '0;
        for (int b = SIG_BYTE; b < CAP_BYTES; b++)
            if (b < len) e.payload[PB-1-8*(b-SIG_BYTE) -: 8] = pkt[b];
        e.cp = 32'(cp); e.cm = 32'(cm); e.ce = 32'(ce);
        sb.push_back(e);
    endtask

    // Present beat k of pkt at a negedge and hold it until the next posedge accepts it.
    task automatic drive_beat(input int k, input bit last, input int nbytes);
        int w = 0;
        @(negedge clk);
        for (int i = 0; i < KW; i++) begin
            bus.s_tdata[DW-1-8*i -: 8] = pkt[k*KW+i];
            bus.s_tkeep[KW-1-i]        = last ? (i < nbytes) : 1'b1;
        end
        bus.s_tlast  = last;
        bus.s_tvalid = 1'b1;
        if (k >= MB) check("drain_tready", 512'(bus.s_tready), 512'(1'b1));
        while (!bus.s_tready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!bus.s_tready) begin
            n_checks++;
            n_fail++;
            $display("FAIL beat_accept: beat %0d not accepted within %0d cycles, required acceptance", k, w);
        end
    endtask

    task automatic send_packet(input int nbeats, input int last_bytes, input int gap);
        for (int k = 0; k < nbeats; k++) begin
            drive_beat(k, k == nbeats - 1, last_bytes);
            if (gap > 0 && k < nbeats - 1) begin
                @(negedge clk);
                bus.s_tvalid = 1'b0;
                repeat (gap - 1) @(negedge clk);
            end
        end
        @(negedge clk);
        bus.s_tvalid = 1'b0;
        bus.s_tlast  = 1'b0;
    endtask

    task automatic wait_drain();
        int w = 0;
        while (sb.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results pending, required 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    // Monitor: compare presented results against the queue; pop on handshake.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst && bus.m_valid) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_m_valid: got m_valid=1, required no result pending");
                end else begin
                    exp_t e;
                    e = sb[0];
                    check("dest_ip",   512'(bus.dest_ip),   512'(e.ip));
                    check("dest_port", 512'(bus.dest_port), 512'(e.port));
                    check("payload",   512'(bus.payload),   512'(e.payload));
                    check("match",     512'(bus.match),     512'(e.m));
                    check("match_idx", 512'(bus.match_idx), 512'(e.idx));
                    check("err_short", 512'(bus.err_short), 512'(e.es));
                    check("err_long",  512'(bus.err_long),  512'(e.el));
                    check("cnt_pkts",  512'(cnt_pkts),      512'(e.cp));
                    check("cnt_match", 512'(cnt_match),     512'(e.cm));
                    check("cnt_err",   512'(cnt_err),       512'(e.ce));
                    if (bus.m_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        bus.s_tdata = '0; bus.s_tkeep = '0; bus.s_tvalid = 1'b0; bus.s_tlast = 1'b0;
        bus.m_ready = 1'b1;
        sig_table = {64'd0, PNG};
        sig_enable = 2'b01;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tready",  512'(bus.s_tready), 512'(1'b0));
        check("rst_m_valid", 512'(bus.m_valid),  512'(1'b0));
        check("rst_cnt",     512'({cnt_pkts, cnt_match, cnt_err}), 512'(0));
        check("rst_dest_ip", 512'(bus.dest_ip),  512'(0));
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_tready", 512'(bus.s_tready), 512'(1'b1));

        // T1: 3-beat PNG hit on entry 0, latency tlast+2
        fill_packet(1, 32'hC0A8010A, 16'h1F90, PNG);
        push_exp(32'hC0A8010A, 16'h1F90, 96, 1'b1, 4'd0, 1'b0, 1'b0, 1, 1, 0);
        send_packet(3, KW, 0);
        check("lat_tlast_plus1", 512'(bus.m_valid), 512'(1'b0));
        @(negedge clk);
        check("lat_tlast_plus2", 512'(bus.m_valid), 512'(1'b1));
        wait_drain();

        // T2: entry 0 disabled, entry 1 hits; beats separated by idle gaps
        sig_table = {PNG, PNG};
        sig_enable = 2'b10;
        fill_packet(2, 32'h0A000001, 16'h0050, PNG);
        push_exp(32'h0A000001, 16'h0050, 96, 1'b1, 4'd1, 1'b0, 1'b0, 2, 2, 0);
        send_packet(3, KW, 2);
        wait_drain();

        // T3: both entries hit, lowest index wins
        sig_enable = 2'b11;
        fill_packet(3, 32'hAC100005, 16'h01BB, PNG);
        push_exp(32'hAC100005, 16'h01BB, 96, 1'b1, 4'd0, 1'b0, 1'b0, 3, 3, 0);
        send_packet(3, KW, 0);
        wait_drain();

        // T4: 2 beats, 60 bytes -> too short, no match
        fill_packet(4, 32'h01020304, 16'h1234, PNG);
        push_exp(32'h01020304, 16'h1234, 60, 1'b0, 4'd0, 1'b1, 1'b0, 4, 3, 1);
        send_packet(2, 28, 0);
        wait_drain();

        // T5: 2 beats, exactly 62 bytes -> signature fits, match
        fill_packet(5, 32'h05060708, 16'h5678, PNG);
        push_exp(32'h05060708, 16'h5678, 62, 1'b1, 4'd0, 1'b0, 1'b0, 5, 4, 1);
        send_packet(2, 30, 0);
        wait_drain();

        // T5b: full packet with a signature in neither entry
        fill_packet(6, 32'hFFFFFFFE, 16'hABCD, OTHER);
        push_exp(32'hFFFFFFFE, 16'hABCD, 96, 1'b0, 4'd0, 1'b0, 1'b0, 6, 4, 1);
        send_packet(3, KW, 0);
        wait_drain();

        // T6: 5-beat packet -> drained, err_long, classified from first 3 beats
        fill_packet(7, 32'h7F000001, 16'h0016, PNG);
        push_exp(32'h7F000001, 16'h0016, 96, 1'b1, 4'd0, 1'b0, 1'b1, 7, 5, 2);
        send_packet(5, KW, 0);
        wait_drain();

        // T7: following normal packet is clean
        sig_enable = 2'b10;
        fill_packet(8, 32'h08080808, 16'h0035, PNG);
        push_exp(32'h08080808, 16'h0035, 96, 1'b1, 4'd1, 1'b0, 1'b0, 8, 6, 2);
        send_packet(3, KW, 0);
        wait_drain();

        // T8: result held with m_ready low; upstream blocked; table change deferred
        sig_table = {DEAD, PNG};
        sig_enable = 2'b10;
        bus.m_ready = 1'b0;
        fill_packet(9, 32'hC6336401, 16'h2710, DEAD);
        push_exp(32'hC6336401, 16'h2710, 96, 1'b1, 4'd1, 1'b0, 1'b0, 9, 7, 2);
        send_packet(3, KW, 0);
        w = 0;
        while (!bus.m_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("stall_m_valid", 512'(bus.m_valid), 512'(1'b1));
        sig_enable = 2'b00;
        for (int c = 0; c < 10; c++) begin
            check("stall_tready", 512'(bus.s_tready), 512'(1'b0));
            bus.s_tvalid = 1'b1;
            bus.s_tlast  = 1'b1;
            bus.s_tkeep  = '1;
            @(negedge clk);
        end
        bus.s_tvalid = 1'b0;
        bus.s_tlast  = 1'b0;
        bus.m_ready  = 1'b1;
        @(negedge clk);
        check("release_m_valid", 512'(bus.m_valid),  512'(1'b0));
        check("release_tready",  512'(bus.s_tready), 512'(1'b1));
        wait_drain();

        // T9: reset after beat 1 of a 3-beat packet, then a clean packet
        sig_table = {PNG, PNG};
        sig_enable = 2'b11;
        fill_packet(10, 32'h11223344, 16'h4455, PNG);
        drive_beat(0, 1'b0, KW);
        drive_beat(1, 1'b0, KW);
        @(negedge clk);
        bus.s_tvalid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_tready",    512'(bus.s_tready),  512'(1'b0));
        check("mid_rst_m_valid",   512'(bus.m_valid),   512'(1'b0));
        check("mid_rst_dest_ip",   512'(bus.dest_ip),   512'(0));
        check("mid_rst_dest_port", 512'(bus.dest_port), 512'(0));
        check("mid_rst_payload",   512'(bus.payload),   512'(0));
        check("mid_rst_flags",     512'({bus.match, bus.match_idx, bus.err_short, bus.err_long}), 512'(0));
        check("mid_rst_cnt",       512'({cnt_pkts, cnt_match, cnt_err}), 512'(0));
        rst = 1'b0;
        fill_packet(11, 32'h99887766, 16'hBEEF, PNG);
        push_exp(32'h99887766, 16'hBEEF, 96, 1'b1, 4'd0, 1'b0, 1'b0, 1, 1, 0);
        send_packet(3, KW, 0);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
